// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch / program-counter stage.
// Holds the FSM state encoding and the absolute/relative branch-target tables.
// Pure declarations: no logic, latency or flow control of its own.
package fetch_pkg;

   localparam int PC_W   = 16;
   localparam int LUT_AW = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam logic [15:0] LUT_ABS [4] = '{16'h0000, 16'h0008, 16'h0010, 16'h0020};

   // Relative offsets are two's-complement and get sign-extended to PC_W.
   localparam logic signed [15:0] LUT_REL [4] = '{16'sd2, 16'sd4, -16'sd3, -16'sd8};

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup: instruction LUT index -> absolute target and relative offset.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the index every cycle.
module branch_lut
   import fetch_pkg::*;
#(
   parameter int LUT_AW_P = fetch_pkg::LUT_AW
) (
   input  logic [LUT_AW_P-1:0] lut_idx,
   output logic [15:0]         abs_tgt,
   output logic signed [15:0]  rel_off
);

   // Indices beyond the populated tables fall back to a harmless zero target/offset.
   always_comb begin
      abs_tgt = 16'h0000;
      rel_off = 16'sd0;
      case (32'(lut_idx))
         0: begin
            abs_tgt = LUT_ABS[0];
            rel_off = LUT_REL[0];
         end
         1: begin
            abs_tgt = LUT_ABS[1];
            rel_off = LUT_REL[1];
         end
         2: begin
            abs_tgt = LUT_ABS[2];
            rel_off = LUT_REL[2];
         end
         3: begin
            abs_tgt = LUT_ABS[3];
            rel_off = LUT_REL[3];
         end
         default: begin
            abs_tgt = 16'h0000;
            rel_off = 16'sd0;
         end
      endcase
   end

endmodule

// File: rtl/fetch_pc.sv
// Program counter and fetch control feeding a combinational instruction ROM.
// Latency: next PC registered one cycle after decode; outputs come only from state.
// Backpressure: Stall freezes PC and retire count; Halt wins over Stall.
module fetch_pc
   import fetch_pkg::*;
#(
   parameter int              PC_W_P     = fetch_pkg::PC_W,
   parameter int              LUT_AW_P   = fetch_pkg::LUT_AW,
   parameter logic [PC_W_P-1:0] START_ADDR = '0
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic                Start,
   input  logic                Stall,
   input  logic                Halt,
   input  logic                BranchAbs,
   input  logic                BranchRel,
   input  logic                Taken,
   input  logic [LUT_AW_P-1:0] LutIdx,
   output logic [PC_W_P-1:0]   PC,
   output logic                Running,
   output logic                Done,
   output logic [15:0]         InstCount
);

   fetch_state_t        state_q, state_d;
   logic [PC_W_P-1:0]   pc_q, pc_d;
   logic [15:0]         cnt_q, cnt_d;

   logic [15:0]         abs_tgt;
   logic signed [15:0]  rel_off;
   logic [PC_W_P-1:0]   pc_seq, pc_abs, pc_rel;
   logic [15:0]         cnt_inc;

   branch_lut #(
      .LUT_AW_P (LUT_AW_P)
   ) u_branch_lut (
      .lut_idx (LutIdx),
      .abs_tgt (abs_tgt),
      .rel_off (rel_off)
   );

   // All PC arithmetic wraps modulo 2**PC_W; the size cast sign-extends rel_off.
   assign pc_seq  = pc_q + PC_W_P'(1);
   assign pc_abs  = PC_W_P'(abs_tgt);
   assign pc_rel  = pc_q + PC_W_P'(rel_off);
   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, HALTED: begin
            if (Start) begin
               state_d = RUN;
               pc_d    = START_ADDR;
               cnt_d   = 16'd0;
            end
         end
         RUN: begin
            if (Halt) begin
               // PC stays on the halt instruction; the halt itself retires.
               state_d = HALTED;
               cnt_d   = cnt_inc;
            end else if (!Stall) begin
               cnt_d = cnt_inc;
               if (BranchAbs && Taken) begin
                  pc_d = pc_abs;
               end else if (BranchRel && Taken) begin
                  pc_d = pc_rel;
               end else begin
                  pc_d = pc_seq;
               end
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = START_ADDR;
            cnt_d   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         pc_q  <= START_ADDR;
         cnt_q <= 16'd0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   assign PC        = pc_q;
   assign Running   = (state_q == RUN);
   assign Done      = (state_q == HALTED);
   assign InstCount = cnt_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Randomised and directed bench for fetch_pc against a behavioural PC/state model.
module tb_fetch_pc;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic        Stall = 1'b0;
   logic        Halt = 1'b0;
   logic        BranchAbs = 1'b0;
   logic        BranchRel = 1'b0;
   logic        Taken = 1'b0;
   logic [1:0]  LutIdx = 2'd0;
   logic [15:0] PC;
   logic        Running;
   logic        Done;
   logic [15:0] InstCount;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: 0 = idle, 1 = running, 2 = halted
   int m_st  = 0;
   int m_pc  = 0;
   int m_cnt = 0;
   int abs_tab [4] = '{0, 8, 16, 32};
   int rel_tab [4] = '{2, 4, -3, -8};

   always #5 CLK = ~CLK;

   fetch_pc dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Start     (Start),
      .Stall     (Stall),
      .Halt      (Halt),
      .BranchAbs (BranchAbs),
      .BranchRel (BranchRel),
      .Taken     (Taken),
      .LutIdx    (LutIdx),
      .PC        (PC),
      .Running   (Running),
      .Done      (Done),
      .InstCount (InstCount)
   );

   task automatic step(input logic rst, input logic sta, input logic stl, input logic hlt,
                       input logic ba, input logic br, input logic tk, input logic [1:0] idx);
      Reset = rst; Start = sta; Stall = stl; Halt = hlt;
      BranchAbs = ba; BranchRel = br; Taken = tk; LutIdx = idx;
      @(posedge CLK);
      if (rst) begin
         m_st = 0; m_pc = 0; m_cnt = 0;
      end else if (m_st != 1) begin
         if (sta) begin
            m_st = 1; m_pc = 0; m_cnt = 0;
         end
      end else if (hlt) begin
         m_st = 2;
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else if (!stl) begin
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         if (ba && tk)      m_pc = abs_tab[idx];
         else if (br && tk) m_pc = (m_pc + rel_tab[idx] + 65536) % 65536;
         else               m_pc = (m_pc + 1) % 65536;
      end
      #1;
   endtask

   task automatic plain(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 2'd0);
   endtask

   task automatic restart_to(input int n);
      step(1, 0, 0, 0, 0, 0, 0, 2'd0);
      step(0, 1, 0, 0, 0, 0, 0, 2'd0);
      plain(n);
   endtask

   task automatic test_reset;
      step(1, 0, 0, 0, 0, 0, 0, 2'd0);
      n_checks++;
      if ({PC, Running, Done, InstCount} !== {16'h0000, 1'b0, 1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL reset: pc=%h run=%b done=%b cnt=%0d, want 0000/0/0/0", PC, Running, Done, InstCount);
      end
      step(0, 0, 1, 1, 1, 1, 1, 2'd3);
      n_checks++;
      if ({PC, Running, Done} !== {16'h0000, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL idle_ignores: pc=%h run=%b done=%b, want 0000/0/0", PC, Running, Done);
      end
   endtask

   task automatic test_sequential;
      step(0, 1, 0, 0, 0, 0, 0, 2'd0);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({PC, Running, Done, InstCount} !== {16'(i), 1'b1, 1'b0, 16'(i)}) begin
            n_fail++;
            $display("FAIL seq[%0d]: pc=%h run=%b done=%b cnt=%0d, want pc=%h run=1 done=0 cnt=%0d",
                     i, PC, Running, Done, InstCount, 16'(i), i);
         end
         step(0, 1, 0, 0, 0, 0, 0, 2'd0);
      end
   endtask

   task automatic test_branch_rel;
      restart_to(7);
      step(0, 0, 0, 0, 0, 1, 1, 2'd2);
      n_checks++;
      if (PC !== 16'd4) begin
         n_fail++;
         $display("FAIL rel_taken: pc=%h, want 0004", PC);
      end
      restart_to(7);
      step(0, 0, 0, 0, 0, 1, 0, 2'd2);
      n_checks++;
      if (PC !== 16'd8) begin
         n_fail++;
         $display("FAIL rel_not_taken: pc=%h, want 0008", PC);
      end
   endtask

   task automatic test_branch_abs;
      restart_to(6);
      step(0, 0, 0, 0, 1, 0, 1, 2'd1);
      n_checks++;
      if (PC !== 16'd8) begin
         n_fail++;
         $display("FAIL abs_taken: pc=%h, want 0008", PC);
      end
      restart_to(6);
      step(0, 0, 0, 0, 1, 1, 1, 2'd1);
      n_checks++;
      if (PC !== 16'd8) begin
         n_fail++;
         $display("FAIL abs_over_rel: pc=%h, want 0008", PC);
      end
      step(0, 0, 0, 0, 1, 0, 1, 2'd3);
      n_checks++;
      if (PC !== 16'h0020) begin
         n_fail++;
         $display("FAIL abs_idx3: pc=%h, want 0020", PC);
      end
   endtask

   task automatic test_stall_halt;
      restart_to(5);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, 1, 0, 1, 2'd3);
         n_checks++;
         if ({PC, InstCount, Running} !== {16'd5, 16'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL stall[%0d]: pc=%h cnt=%0d run=%b, want 0005/5/1", i, PC, InstCount, Running);
         end
      end
      step(0, 0, 1, 1, 0, 0, 0, 2'd0);
      n_checks++;
      if ({PC, InstCount, Running, Done} !== {16'd5, 16'd6, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL halt_stall: pc=%h cnt=%0d run=%b done=%b, want 0005/6/0/1", PC, InstCount, Running, Done);
      end
   endtask

   task automatic test_halt_restart;
      restart_to(9);
      step(0, 0, 0, 1, 0, 0, 0, 2'd0);
      step(0, 0, 0, 0, 1, 0, 1, 2'd2);
      n_checks++;
      if ({PC, Done, Running, InstCount} !== {16'd9, 1'b1, 1'b0, 16'd10}) begin
         n_fail++;
         $display("FAIL halted: pc=%h done=%b run=%b cnt=%0d, want 0009/1/0/10", PC, Done, Running, InstCount);
      end
      step(0, 1, 0, 0, 0, 0, 0, 2'd0);
      n_checks++;
      if ({PC, Done, Running, InstCount} !== {16'd0, 1'b0, 1'b1, 16'd0}) begin
         n_fail++;
         $display("FAIL restart: pc=%h done=%b run=%b cnt=%0d, want 0000/0/1/0", PC, Done, Running, InstCount);
      end
   endtask

   task automatic test_wrap_reset;
      logic [15:0] want [3];
      want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000;
      restart_to(1);
      step(0, 0, 0, 0, 0, 1, 1, 2'd2);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (PC !== want[i]) begin
            n_fail++;
            $display("FAIL wrap[%0d]: pc=%h, want %h", i, PC, want[i]);
         end
         plain(1);
      end
      step(0, 0, 0, 0, 0, 1, 1, 2'd3);
      n_checks++;
      if (PC !== 16'hFFF9) begin
         n_fail++;
         $display("FAIL wrap_neg8: pc=%h, want fff9", PC);
      end
      restart_to(5);
      step(1, 0, 0, 0, 1, 0, 1, 2'd3);
      n_checks++;
      if ({PC, Running, Done, InstCount} !== {16'd0, 1'b0, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_midrun: pc=%h run=%b done=%b cnt=%0d, want 0000/0/0/0", PC, Running, Done, InstCount);
      end
   endtask

   task automatic test_saturation;
      restart_to(65540);
      n_checks++;
      if ({InstCount, PC} !== {16'hFFFF, 16'd4}) begin
         n_fail++;
         $display("FAIL saturate: cnt=%h pc=%h, want ffff/0004", InstCount, PC);
      end
      step(0, 0, 0, 1, 0, 0, 0, 2'd0);
      n_checks++;
      if ({InstCount, Done} !== {16'hFFFF, 1'b1}) begin
         n_fail++;
         $display("FAIL saturate_halt: cnt=%h done=%b, want ffff/1", InstCount, Done);
      end
   endtask

   task automatic test_random;
      logic rst, sta, stl, hlt, ba, br, tk;
      logic [1:0] idx;
      step(1, 0, 0, 0, 0, 0, 0, 2'd0);
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         sta = ($urandom_range(0, 14) == 0);
         stl = ($urandom_range(0, 4) == 0);
         hlt = ($urandom_range(0, 39) == 0);
         ba  = ($urandom_range(0, 5) == 0);
         br  = ($urandom_range(0, 4) == 0);
         tk  = 1'($urandom_range(0, 1));
         idx = 2'($urandom_range(0, 3));
         step(rst, sta, stl, hlt, ba, br, tk, idx);
         n_checks++;
         if ({PC, Running, Done, InstCount} !== {16'(m_pc), m_st == 1, m_st == 2, 16'(m_cnt)}) begin
            n_fail++;
            $display("FAIL random[%0d]: pc=%h run=%b done=%b cnt=%0d, want pc=%h run=%b done=%b cnt=%0d",
                     i, PC, Running, Done, InstCount, 16'(m_pc), m_st == 1, m_st == 2, m_cnt);
         end
      end
   endtask

   initial begin
      #2;
      test_reset;
      test_sequential;
      test_branch_rel;
      test_branch_abs;
      test_stall_halt;
      test_halt_restart;
      test_wrap_reset;
      test_random;
      test_saturation;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
